up_core: RTL and testbench
==========================

UP_CORE -- requirements
Module: up_core

Interface
REQ-001 SHALL provide: clk  in  1  single rising-edge clock; all state changes on this edge.
REQ-002 SHALL provide: nRst  in  1  reset; synchronous, active-high (port name retained from codebase).
REQ-003 SHALL provide: int  in  1  interrupt request; a falling edge raises a request.
REQ-004 SHALL provide: load  in  1  program-load mode; 1 = shift mem_in into memory, CPU held.
REQ-005 SHALL provide: mem_in  in  8  serial program byte, one per clock while load=1.
REQ-006 SHALL provide: mem_map_in_0..3  in  9 each  bit8 = write strobe, bits7:0 = data for mem[0xF8+n].
REQ-007 SHALL provide: mem_out  out  8  = mem[0xFF] (shift-chain tail).
REQ-008 SHALL provide: mem_map_out_0..3  out  8 each  = mem[0xFC+n], combinational from memory.

Function
REQ-009 SHALL contain 256x8 unified program/data memory, 8-bit PC, IR, operand register OP, accumulator A, flags Z and C, interrupt-enable IE, return register RET, pending flag IP.
REQ-010 SHALL, while load=1: mem[k]<=mem[k-1] for k=255..1, mem[0]<=mem_in; PC<=0; state<=FETCH; no CPU activity; 256 loads of bytes b255..b0 leave mem[k]=bk.
REQ-011 SHALL write mem[0xF8+n]<=mem_map_in_n[7:0] every cycle mem_map_in_n[8]=1 and load=0; priority load > map write > CPU store to the same address.
REQ-012 SHALL sequence FETCH (IR<=mem[PC], PC++), OPERAND (two-byte ops only: OP<=mem[PC], PC++), EXEC; one-byte ops take 2 cycles, two-byte ops 3 cycles.
REQ-013 SHALL decode opcode IR[7:4], IR[3:0] ignored: 0 NOP; 1 LDI imm A<=OP; 2 LD A<=mem[OP]; 3 ST mem[OP]<=A; 4 ADD A<=A+mem[OP], C=carry; 5 SUB A<=A-mem[OP], C=borrow; 6 AND; 7 OR; 8 XOR (A op mem[OP]); 9 JMP PC<=OP; A JZ if Z; B JC if C; C EI; D DI; E RETI PC<=RET, IE<=1; F HALT (PC<=PC-1, re-executes).
REQ-014 SHALL update Z (A==0) on LDI, LD, ADD, SUB, AND, OR, XOR; C only on ADD/SUB; other ops preserve flags.
REQ-015 SHALL wrap PC 0xFF->0x00 and ALU results modulo 256.
REQ-016 SHALL sample int into a register and set IP on a 1->0 transition; IP stays set until serviced.
REQ-017 SHALL, on entry to FETCH with IP=1 and IE=1: RET<=PC, IE<=0, IP<=0, PC<=0xE0, consuming one cycle instead of a fetch; HALT is interruptible.
REQ-018 SHALL keep IP set but not service it while IE=0; new edges while IP=1 are merged.
REQ-019 SHALL read memory combinationally (register array), write synchronously.

Reset
REQ-020 SHALL, when nRst=1 on a clock edge: clear all memory, PC, IR, OP, A, Z, C, IE, IP, RET; sampled int<=1; state<=FETCH; all outputs 0 the following cycle.
REQ-021 SHALL give reset priority over load and map writes; reset mid-instruction abandons it.

Structure
REQ-022 SHALL place opcode constants, state encoding, vector 0xE0 and map bases 0xF8/0xFC in a shared package up_core_pkg.
REQ-023 SHALL be one module with one natural sub-module up_core_alu (A, operand, opcode -> result, Z, C).

Verification
REQ-024 Reset: pulse nRst=1 one cycle -> mem_out=0, all mem_map_out=0, PC=0.
REQ-025 Load: feed bytes 255..0 over 256 cycles -> mem[k]=k, mem_out=0xFF, mem_map_out_0=0xFC.
REQ-026 Program 10 2A 30 FC F0 -> mem_map_out_0=0x2A six cycles after load falls; HALT holds.
REQ-027 mem_map_in_0=0x102, program 20 F8 30 FD F0 -> mem_map_out_1=0x02.
REQ-028 Program 10 FF 40 10 B0 20 with mem[0x10]=01 -> A=0, Z=1, C=1, jump to 0x20 taken.
REQ-029 EI; HALT loop, ISR at 0xE0 increments mem[0xFC] then RETI; 4 int low pulses -> mem_map_out_0=4; with IE=0 -> stays 0.

Source files
------------

// File: rtl/up_core_pkg.sv
// Shared definitions for the up_core processor: opcodes, sequencer states,
// interrupt vector and the memory-mapped I/O window bases.
package up_core_pkg;

  typedef enum logic [3:0] {
    OPC_NOP  = 4'h0,
    OPC_LDI  = 4'h1,
    OPC_LD   = 4'h2,
    OPC_ST   = 4'h3,
    OPC_ADD  = 4'h4,
    OPC_SUB  = 4'h5,
    OPC_AND  = 4'h6,
    OPC_OR   = 4'h7,
    OPC_XOR  = 4'h8,
    OPC_JMP  = 4'h9,
    OPC_JZ   = 4'hA,
    OPC_JC   = 4'hB,
    OPC_EI   = 4'hC,
    OPC_DI   = 4'hD,
    OPC_RETI = 4'hE,
    OPC_HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_OPERAND = 2'd1,
    S_EXEC    = 2'd2
  } state_t;

  localparam logic [7:0] IRQ_VECTOR   = 8'hE0;
  localparam logic [7:0] MAP_IN_BASE  = 8'hF8;
  localparam logic [7:0] MAP_OUT_BASE = 8'hFC;

  // Opcodes LDI..JC carry an operand byte after the opcode byte.
  function automatic logic is_two_byte(input logic [3:0] opc);
    return (opc >= 4'h1) && (opc <= 4'hB);
  endfunction

endpackage

// File: rtl/up_core_alu.sv
// Combinational ALU: result, zero flag and carry/borrow for the data ops.
module up_core_alu
  import up_core_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] operand,
  input  opcode_t    opcode,
  output logic [7:0] result,
  output logic       z,
  output logic       c
);

  logic [8:0] wide;

  // Bit 8 holds the carry for ADD and the borrow for SUB.
  always_comb begin
    wide = 9'd0;
    case (opcode)
      OPC_ADD: wide = {1'b0, a} + {1'b0, operand};
      OPC_SUB: wide = {1'b0, a} - {1'b0, operand};
      OPC_AND: wide = {1'b0, a & operand};
      OPC_OR:  wide = {1'b0, a | operand};
      OPC_XOR: wide = {1'b0, a ^ operand};
      default: wide = {1'b0, operand};
    endcase
    result = wide[7:0];
    c      = wide[8];
    z      = (wide[7:0] == 8'd0);
  end

endmodule

// File: rtl/up_core.sv
// 8-bit accumulator CPU with 256-byte unified memory, serial program load,
// memory-mapped I/O at 0xF8..0xFF and a single falling-edge interrupt.
module up_core
  import up_core_pkg::*;
(
  input  logic       clk,
  input  logic       nRst,
  input  logic       intr,
  input  logic       load,
  input  logic [7:0] mem_in,
  input  logic [8:0] mem_map_in_0,
  input  logic [8:0] mem_map_in_1,
  input  logic [8:0] mem_map_in_2,
  input  logic [8:0] mem_map_in_3,
  output logic [7:0] mem_out,
  output logic [7:0] mem_map_out_0,
  output logic [7:0] mem_map_out_1,
  output logic [7:0] mem_map_out_2,
  output logic [7:0] mem_map_out_3
);

  logic [7:0] mem [256];
  logic [8:0] map_in [4];
  logic [7:0] map_out [4];

  state_t     state_reg, state_next;
  logic [7:0] pc_reg, op_reg, a_reg, ret_reg;
  logic [3:0] ir_reg;   // only the opcode nibble is kept; the low nibble has no meaning
  logic       z_reg, c_reg, ie_reg, ip_reg, int_reg;

  logic       irq_take, do_fetch, do_operand, do_exec;
  logic [7:0] mem_rd, alu_operand, alu_result;
  logic       alu_z, alu_c;
  opcode_t    exec_opc;

  assign map_in[0] = mem_map_in_0;
  assign map_in[1] = mem_map_in_1;
  assign map_in[2] = mem_map_in_2;
  assign map_in[3] = mem_map_in_3;

  for (genvar gi = 0; gi < 4; gi++) begin : g_map_out
    assign map_out[gi] = mem[MAP_OUT_BASE + 8'(gi)];
  end

  assign mem_map_out_0 = map_out[0];
  assign mem_map_out_1 = map_out[1];
  assign mem_map_out_2 = map_out[2];
  assign mem_map_out_3 = map_out[3];
  assign mem_out       = mem[8'hFF];

  assign mem_rd      = mem[pc_reg];
  assign exec_opc    = opcode_t'(ir_reg);
  assign alu_operand = (exec_opc == OPC_LDI) ? op_reg : mem[op_reg];

  up_core_alu u_alu (
    .a       (a_reg),
    .operand (alu_operand),
    .opcode  (exec_opc),
    .result  (alu_result),
    .z       (alu_z),
    .c       (alu_c)
  );

  always_ff @(posedge clk) begin
    if (nRst || load) state_reg <= S_FETCH;
    else              state_reg <= state_next;
  end

  // A FETCH slot taken by interrupt entry stays in FETCH for the real fetch.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: begin
        if (!(ip_reg && ie_reg))
          state_next = is_two_byte(mem_rd[7:4]) ? S_OPERAND : S_EXEC;
      end
      S_OPERAND: state_next = S_EXEC;
      S_EXEC:    state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  always_comb begin
    irq_take   = 1'b0;
    do_fetch   = 1'b0;
    do_operand = 1'b0;
    do_exec    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (ip_reg && ie_reg) irq_take = 1'b1;
        else                  do_fetch = 1'b1;
      end
      S_OPERAND: do_operand = 1'b1;
      S_EXEC:    do_exec    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      pc_reg  <= 8'd0;
      ir_reg  <= 4'd0;
      op_reg  <= 8'd0;
      a_reg   <= 8'd0;
      ret_reg <= 8'd0;
      z_reg   <= 1'b0;
      c_reg   <= 1'b0;
      ie_reg  <= 1'b0;
      ip_reg  <= 1'b0;
      int_reg <= 1'b1;
    end else begin
      int_reg <= intr;
      if (load) begin
        pc_reg <= 8'd0;
      end else if (irq_take) begin
        ret_reg <= pc_reg;
        ie_reg  <= 1'b0;
        ip_reg  <= 1'b0;
        pc_reg  <= IRQ_VECTOR;
      end else if (do_fetch) begin
        ir_reg <= mem_rd[7:4];
        pc_reg <= pc_reg + 8'd1;
      end else if (do_operand) begin
        op_reg <= mem_rd;
        pc_reg <= pc_reg + 8'd1;
      end else if (do_exec) begin
        case (exec_opc)
          OPC_LDI, OPC_LD, OPC_AND, OPC_OR, OPC_XOR: begin
            a_reg <= alu_result;
            z_reg <= alu_z;
          end
          OPC_ADD, OPC_SUB: begin
            a_reg <= alu_result;
            z_reg <= alu_z;
            c_reg <= alu_c;
          end
          OPC_JMP:  pc_reg <= op_reg;
          OPC_JZ:   if (z_reg) pc_reg <= op_reg;
          OPC_JC:   if (c_reg) pc_reg <= op_reg;
          OPC_EI:   ie_reg <= 1'b1;
          OPC_DI:   ie_reg <= 1'b0;
          OPC_RETI: begin
            pc_reg <= ret_reg;
            ie_reg <= 1'b1;
          end
          OPC_HALT: pc_reg <= pc_reg - 8'd1;
          default: ;
        endcase
      end
      // Placed after the service clear so an edge arriving that cycle is not lost.
      if (int_reg && !intr) ip_reg <= 1'b1;
    end
  end

  // Later assignments win: map writes override a CPU store to the same byte.
  always_ff @(posedge clk) begin
    if (nRst) begin
      for (int i = 0; i < 256; i++) mem[8'(i)] <= 8'd0;
    end else if (load) begin
      for (int k = 255; k > 0; k--) mem[8'(k)] <= mem[8'(k - 1)];
      mem[8'd0] <= mem_in;
    end else begin
      if (do_exec && (exec_opc == OPC_ST)) mem[op_reg] <= a_reg;
      for (int n = 0; n < 4; n++) begin
        if (map_in[n][8]) mem[MAP_IN_BASE + 8'(n)] <= map_in[n][7:0];
      end
    end
  end

endmodule

// File: tb/tb_up_core.sv
// Directed bench for up_core: ALU vector table plus hand-written program
// sequences covering load, map I/O, jumps, PC wrap and interrupts.
module tb_up_core;

  logic       clk = 1'b0;
  logic       nRst, intr, load;
  logic [7:0] mem_in;
  logic [8:0] mi0, mi1, mi2, mi3;
  logic [7:0] mem_out, mo0, mo1, mo2, mo3;

  int total = 0;
  int bad   = 0;

  logic [7:0] img [256];

  typedef struct {
    logic [3:0] opc;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vecs [12];

  up_core dut (
    .clk           (clk),
    .nRst          (nRst),
    .intr          (intr),
    .load          (load),
    .mem_in        (mem_in),
    .mem_map_in_0  (mi0),
    .mem_map_in_1  (mi1),
    .mem_map_in_2  (mi2),
    .mem_map_in_3  (mi3),
    .mem_out       (mem_out),
    .mem_map_out_0 (mo0),
    .mem_map_out_1 (mo1),
    .mem_map_out_2 (mo2),
    .mem_map_out_3 (mo3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; one posedge sees reset asserted.
  task automatic do_reset();
    nRst = 1'b1;
    @(negedge clk);
    nRst = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  // Shifts img[255] first so that img[k] lands in mem[k]; returns at the
  // negedge where load has just fallen.
  task automatic load_img();
    for (int k = 255; k >= 0; k--) begin
      @(negedge clk);
      load   = 1'b1;
      mem_in = img[k];
    end
    @(negedge clk);
    load   = 1'b0;
    mem_in = 8'h00;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRst = 1'b1; intr = 1'b1; load = 1'b0; mem_in = 8'h00;
    mi0 = 9'h000; mi1 = 9'h000; mi2 = 9'h000; mi3 = 9'h000;

    vecs[0]  = '{4'h4, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0};
    vecs[1]  = '{4'h4, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[2]  = '{4'h4, 8'h80, 8'h90, 8'h10, 1'b0, 1'b1};
    vecs[3]  = '{4'h5, 8'h50, 8'h20, 8'h30, 1'b0, 1'b0};
    vecs[4]  = '{4'h5, 8'h20, 8'h50, 8'hD0, 1'b0, 1'b1};
    vecs[5]  = '{4'h5, 8'h42, 8'h42, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{4'h6, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[7]  = '{4'h6, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{4'h7, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0};
    vecs[9]  = '{4'h8, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{4'h8, 8'h5A, 8'hFF, 8'hA5, 1'b0, 1'b0};
    vecs[11] = '{4'h2, 8'h77, 8'h00, 8'h00, 1'b1, 1'b0};

    // Reset state
    @(negedge clk);
    nRst = 1'b0;
    check("rst mem_out", mem_out, 8'h00);
    check("rst map0", mo0, 8'h00);
    check("rst map3", mo3, 8'h00);
    check("rst pc", dut.pc_reg, 8'h00);

    // Ramp load: mem[k] = k
    clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'(i);
    load_img();
    check("load mem_out", mem_out, 8'hFF);
    check("load map0", mo0, 8'hFC);
    check("load map1", mo1, 8'hFD);
    check("load map2", mo2, 8'hFE);
    do_reset();
    check("rst2 map0", mo0, 8'h00);
    check("rst2 map2", mo2, 8'h00);
    check("rst2 mem_out", mem_out, 8'h00);

    // LDI 2A; ST FC; HALT -- store lands on the sixth edge
    clear_img();
    img[0] = 8'h10; img[1] = 8'h2A; img[2] = 8'h30; img[3] = 8'hFC; img[4] = 8'hF0;
    load_img();
    tick(5);
    check("st before 6th edge", mo0, 8'h00);
    tick(1);
    check("st on 6th edge", mo0, 8'h2A);
    tick(20);
    check("halt keeps map0", mo0, 8'h2A);
    check("halt pc", dut.pc_reg & 8'hFE, 8'h04);

    // Map input read back through the CPU
    do_reset();
    clear_img();
    img[0] = 8'h20; img[1] = 8'hF8; img[2] = 8'h30; img[3] = 8'hFD; img[4] = 8'hF0;
    load_img();
    mi0 = 9'h102;
    tick(12);
    check("map in to map1", mo1, 8'h02);
    mi0 = 9'h000;

    // Map write beats CPU store to the same byte
    do_reset();
    clear_img();
    img[0] = 8'h10; img[1] = 8'h55; img[2] = 8'h30; img[3] = 8'hF8;
    img[4] = 8'h20; img[5] = 8'hF8; img[6] = 8'h30; img[7] = 8'hFC; img[8] = 8'hF0;
    load_img();
    mi0 = 9'h1AA;
    tick(20);
    check("map beats store", mo0, 8'hAA);
    mi0 = 9'h000;

    // ALU vector table: LDI a; op [80]; ST FC; HALT
    for (int v = 0; v < 12; v++) begin
      do_reset();
      clear_img();
      img[0] = 8'h10; img[1] = vecs[v].a;
      img[2] = {vecs[v].opc, 4'h0}; img[3] = 8'h80;
      img[4] = 8'h30; img[5] = 8'hFC; img[6] = 8'hF0;
      img[8'h80] = vecs[v].b;
      img[8'hFC] = 8'hEE;
      load_img();
      tick(14);
      check($sformatf("vec%0d result", v), mo0, vecs[v].res);
      check($sformatf("vec%0d z", v), dut.z_reg, vecs[v].z);
      check($sformatf("vec%0d c", v), dut.c_reg, vecs[v].c);
    end

    // Carry survives a logic op
    do_reset();
    clear_img();
    img[0] = 8'h10; img[1] = 8'hFF; img[2] = 8'h40; img[3] = 8'h80;
    img[4] = 8'h70; img[5] = 8'h81; img[6] = 8'h30; img[7] = 8'hFC; img[8] = 8'hF0;
    img[8'h80] = 8'h01; img[8'h81] = 8'h0F;
    load_img();
    tick(18);
    check("or after add map0", mo0, 8'h0F);
    check("or keeps c", dut.c_reg, 1'b1);
    check("or clears z", dut.z_reg, 1'b0);

    // LDI FF; ADD [10]; JC 20 -> ST FC; JZ 30 -> HALT at 30
    do_reset();
    clear_img();
    img[0] = 8'h10; img[1] = 8'hFF; img[2] = 8'h40; img[3] = 8'h10;
    img[4] = 8'hB0; img[5] = 8'h20; img[6] = 8'hF0;
    img[8'h10] = 8'h01;
    img[8'h20] = 8'h30; img[8'h21] = 8'hFC; img[8'h22] = 8'hA0; img[8'h23] = 8'h30;
    img[8'h24] = 8'hF0; img[8'h30] = 8'hF0;
    img[8'hFC] = 8'hAA;
    load_img();
    tick(25);
    check("jc path stored a", mo0, 8'h00);
    check("add wrap a", dut.a_reg, 8'h00);
    check("add wrap z", dut.z_reg, 1'b1);
    check("add wrap c", dut.c_reg, 1'b1);
    check("jz taken pc", dut.pc_reg & 8'hFE, 8'h30);

    // PC wrap: loop body ends with JMP FF; NOP at FF wraps to 00
    do_reset();
    clear_img();
    img[0] = 8'h20; img[1] = 8'hFC; img[2] = 8'h40; img[3] = 8'hD0;
    img[4] = 8'h30; img[5] = 8'hFC; img[6] = 8'h90; img[7] = 8'hFF;
    img[8'hD0] = 8'h01;
    load_img();
    tick(40);
    check("pc wrap loop count", mo0, 8'h03);
    check("pc wrap mem_out", mem_out, 8'h00);

    // Interrupts enabled: EI; HALT; ISR increments FC then RETI
    do_reset();
    clear_img();
    img[0] = 8'hC0; img[1] = 8'hF0;
    img[8'hD0] = 8'h01;
    img[8'hE0] = 8'h20; img[8'hE1] = 8'hFC; img[8'hE2] = 8'h40; img[8'hE3] = 8'hD0;
    img[8'hE4] = 8'h30; img[8'hE5] = 8'hFC; img[8'hE6] = 8'hE0;
    load_img();
    tick(6);
    for (int p = 0; p < 4; p++) begin
      intr = 1'b0;
      tick(2);
      intr = 1'b1;
      tick(30);
    end
    check("irq count", mo0, 8'h04);
    check("irq ie restored", dut.ie_reg, 1'b1);
    check("irq halt pc", dut.pc_reg & 8'hFE, 8'h00);

    // Interrupts disabled: request stays pending, ISR never runs
    do_reset();
    img[0] = 8'hF0; img[1] = 8'h00;
    load_img();
    tick(6);
    for (int p = 0; p < 4; p++) begin
      intr = 1'b0;
      tick(2);
      intr = 1'b1;
      tick(30);
    end
    check("irq masked count", mo0, 8'h00);
    check("irq masked pending", dut.ip_reg, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
